pwl_act: RTL and testbench
==========================

PWL_ACT -- requirements
Module: pwl_act

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 16, meaning the signed two's-complement width of the input and output samples.
REQ-002 SHALL provide parameter FRACT_WIDTH, default 12, meaning the fractional bits of the fixed-point format, with legal range FRACT_WIDTH>=3 and DATA_WIDTH>=FRACT_WIDTH+4.
REQ-003 SHALL provide parameter TAG_WIDTH, default 4, meaning the width of the sideband tag carried alongside each sample.
REQ-004 SHALL provide port clk, input, 1 bit, the system clock.
REQ-005 SHALL provide port rst, input, 1 bit, a synchronous active-low reset.
REQ-006 SHALL provide port in_valid, input, 1 bit, meaning an input sample is offered.
REQ-007 SHALL provide port in_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-008 SHALL provide port in_data, input, DATA_WIDTH bits, the signed sample x.
REQ-009 SHALL provide port in_mode, input, 1 bit, selecting 0=sigmoid and 1=tanh.
REQ-010 SHALL provide port in_tag, input, TAG_WIDTH bits, an opaque sideband value.
REQ-011 SHALL provide port out_valid, output, 1 bit, meaning a result is presented.
REQ-012 SHALL provide port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-013 SHALL provide port out_data, output, DATA_WIDTH bits, the signed result.
REQ-014 SHALL provide port out_tag, output, TAG_WIDTH bits, the in_tag of the same sample.

Function
REQ-015 SHALL accept a sample on a clk edge when in_valid=1 and in_ready=1, and SHALL complete a transfer when out_valid=1 and out_ready=1.
REQ-016 SHALL implement a 3-stage pipeline: S1 = abs/mode prep, S2 = segment evaluation, S3 = sign fold; the latency from acceptance to out_valid SHALL be 3 cycles when there is no stall.
REQ-017 SHALL drive in_ready = !S3_valid || out_ready, SHALL advance all stages together on a global stall, and SHALL sustain a throughput of 1 sample per cycle when out_ready is held at 1.
REQ-018 SHALL hold out_data, out_tag and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 S1 SHALL form a=|x|, saturating to the maximum positive value when x is the most negative value; in tanh mode it SHALL form a=min(2|x|, maximum positive) instead.
REQ-020 S2 SHALL evaluate s(a) using unsigned right shifts, with 1.0 = 1<<FRACT_WIDTH:
  - a >= 5.0 -> 1.0
  - 2.375 <= a < 5.0 -> (a>>5) + 0.84375
  - 1.0 <= a < 2.375 -> (a>>3) + 0.625
  - a < 1.0 -> (a>>2) + 0.5
REQ-021 SHALL represent the thresholds as 5<<FRACT_WIDTH, 19<<(FRACT_WIDTH-3) and 1<<FRACT_WIDTH, with each lower bound inclusive.
REQ-022 In sigmoid mode, S3 SHALL output s for x>=0 and 1.0-s for x<0.
REQ-023 In tanh mode, S3 SHALL output 2s-1.0 for x>=0 and 1.0-2s for x<0.
REQ-024 Each sample's mode and tag SHALL travel with it through the pipeline, so that a mode change between consecutive samples needs no bubble.
REQ-025 The output range SHALL be [0, 1.0] for sigmoid and [-1.0, 1.0] for tanh, and no output SHALL wrap.

Reset
REQ-026 While rst=0 at a clk edge, the block SHALL clear all stage valid bits, set out_valid=0, out_data=0 and out_tag=0, and hold in_ready=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight samples, and no result for them SHALL appear after release.
REQ-028 After rst returns to 1, in_ready SHALL be 1 on the first cycle.

Configuration
REQ-029 The macro PWL_ACT_TANH_EN, when defined, SHALL compile in the tanh path (the doubling in S1 and the 2s-1 fold in S3).
REQ-030 Without PWL_ACT_TANH_EN, in_mode SHALL be ignored, every sample SHALL be processed as sigmoid, and no tanh logic SHALL be synthesised.

Verification (DATA_WIDTH=16, FRACT_WIDTH=12, PWL_ACT_TANH_EN defined)
REQ-031 Sigmoid with x = 0x0000, 0x1000, 0xF000, 0x6000 -> out_data = 0x0800, 0x0C00, 0x0400, 0x1000, each 3 cycles after its acceptance.
REQ-032 Sigmoid with x=0x8000 (most negative) -> 0x0000, and x=0x2600 (exactly 2.375) -> 0x0130+0x0D80=0x0EB0.
REQ-033 Tanh with x = 0x0800, 0x2000, 0xE000 -> 0x0800, 0x0F00, 0xF100.
REQ-034 Back-to-back stream of 8 samples with alternating mode and out_ready toggling 1,0,0,1 -> no loss or duplication, tags emerge in order, and outputs stay stable during stalls.
REQ-035 Reset pulse 1 cycle after 3 samples are accepted -> out_valid stays 0 until new input, and the next sample's result appears 3 cycles after its acceptance.
REQ-036 Build without the macro, in_mode=1 and x=0x1000 -> out_data=0x0C00 (sigmoid result).

Source files
------------

// File: rtl/pwl_act.sv
// Piecewise-linear sigmoid/tanh, 3-stage valid/ready pipeline with global stall.
// Define PWL_ACT_TANH_EN to compile in the tanh path (S1 doubling, S3 2s-1 fold).
module pwl_act #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 12,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int W = DATA_WIDTH;
  localparam int F = FRACT_WIDTH;

  localparam longint L_ONE  = longint'(1) << F;
  localparam longint L_HI   = longint'(5) << F;
  localparam longint L_MID  = longint'(19) << (F - 3);
  localparam longint L_OFS2 = (longint'(27) << F) >> 5;
  localparam longint L_OFS1 = longint'(5) << (F - 3);
  localparam longint L_OFS0 = longint'(1) << (F - 1);
  localparam longint L_MAX  = (longint'(1) << (W - 1)) - 1;

  localparam logic [W-1:0] C_ONE  = W'(L_ONE);
  localparam logic [W-1:0] C_HI   = W'(L_HI);
  localparam logic [W-1:0] C_MID  = W'(L_MID);
  localparam logic [W-1:0] C_OFS2 = W'(L_OFS2);
  localparam logic [W-1:0] C_OFS1 = W'(L_OFS1);
  localparam logic [W-1:0] C_OFS0 = W'(L_OFS0);
  localparam logic [W-1:0] C_MAX  = W'(L_MAX);
  localparam logic [W-1:0] C_MIN  = ~C_MAX;

  logic                 w_adv;
  logic                 w_acc;
  logic                 w_neg;
  logic                 w_mode;
  logic [W-1:0]         w_abs;
  logic [W-1:0]         w_a;
  logic [W-1:0]         w_s;
  logic [W-1:0]         w_out;

  logic                 r1_v, r2_v, r3_v;
  logic [W-1:0]         r1_a, r2_s, r3_d;
  logic                 r1_neg, r2_neg;
  logic                 r1_mode, r2_mode;
  logic [TAG_WIDTH-1:0] r1_tag, r2_tag, r3_tag;

  assign w_adv    = !r3_v || out_ready;
  assign in_ready = rst && w_adv;
  assign w_acc    = in_valid && in_ready;

  // S1: magnitude, saturating the most negative input
  assign w_neg = in_data[W-1];
  always_comb begin
    w_abs = in_data;
    if (in_data == C_MIN)
      w_abs = C_MAX;
    else if (w_neg)
      w_abs = W'(0) - in_data;
  end

`ifdef PWL_ACT_TANH_EN
  logic [W:0] w_dbl;
  assign w_mode = in_mode;
  assign w_dbl  = {1'b0, w_abs} << 1;
  always_comb begin
    w_a = w_abs;
    if (w_mode)
      w_a = (w_dbl > {1'b0, C_MAX}) ? C_MAX : w_dbl[W-1:0];
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = in_mode;
  assign w_mode = 1'b0;
  assign w_a    = w_abs;
`endif

  // S2: segment select, lower bounds inclusive
  always_comb begin
    w_s = C_ONE;
    unique case (1'b1)
      (r1_a >= C_HI):                  w_s = C_ONE;
      (r1_a >= C_MID && r1_a < C_HI):  w_s = (r1_a >> 5) + C_OFS2;
      (r1_a >= C_ONE && r1_a < C_MID): w_s = (r1_a >> 3) + C_OFS1;
      (r1_a < C_ONE):                  w_s = (r1_a >> 2) + C_OFS0;
    endcase
  end

  // S3: sign fold; s lies in [0.5, 1.0] so none of these wrap
`ifdef PWL_ACT_TANH_EN
  logic [W-1:0] w_t;
  always_comb begin
    w_t   = (r2_s << 1) - C_ONE;
    w_out = r2_neg ? (C_ONE - r2_s) : r2_s;
    if (r2_mode)
      w_out = r2_neg ? (W'(0) - w_t) : w_t;
  end
`else
  logic w_unused_m2;
  assign w_unused_m2 = r2_mode;
  assign w_out = r2_neg ? (C_ONE - r2_s) : r2_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r1_v    <= 1'b0;
      r2_v    <= 1'b0;
      r3_v    <= 1'b0;
      r1_a    <= '0;
      r2_s    <= '0;
      r3_d    <= '0;
      r1_neg  <= 1'b0;
      r2_neg  <= 1'b0;
      r1_mode <= 1'b0;
      r2_mode <= 1'b0;
      r1_tag  <= '0;
      r2_tag  <= '0;
      r3_tag  <= '0;
    end else if (w_adv) begin
      r1_v    <= w_acc;
      r1_a    <= w_a;
      r1_neg  <= w_neg;
      r1_mode <= w_mode;
      r1_tag  <= in_tag;
      r2_v    <= r1_v;
      r2_s    <= w_s;
      r2_neg  <= r1_neg;
      r2_mode <= r1_mode;
      r2_tag  <= r1_tag;
      r3_v    <= r2_v;
      r3_d    <= w_out;
      r3_tag  <= r2_tag;
    end
  end

  assign out_valid = r3_v;
  assign out_data  = r3_d;
  assign out_tag   = r3_tag;

endmodule

// File: tb/tb_pwl_act.sv
// Directed bench for pwl_act: latency, values, stalls, reset flush.
// Tanh vectors are expected only when PWL_ACT_TANH_EN is defined.
module tb_pwl_act;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_mode = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_tag;

  int checks = 0;
  int errors = 0;

  pwl_act #(
    .DATA_WIDTH(16),
    .FRACT_WIDTH(12),
    .TAG_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_mode(in_mode),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tg, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tg, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lat(input string tg, input logic [15:0] x,
                     input logic m, input logic [3:0] tag,
                     input logic [15:0] exp);
    in_valid  = 1'b1;
    in_data   = x;
    in_mode   = m;
    in_tag    = tag;
    out_ready = 1'b1;
    #1 chk({tg, "_rdy"}, 32'(in_ready), 1);
    cyc();
    in_valid = 1'b0;
    #1 chk({tg, "_v1"}, 32'(out_valid), 0);
    cyc();
    #1 chk({tg, "_v2"}, 32'(out_valid), 0);
    cyc();
    #1 chk({tg, "_v3"}, 32'(out_valid), 1);
    chk({tg, "_data"}, 32'(out_data), 32'(exp));
    chk({tg, "_tag"}, 32'(out_tag), 32'(tag));
    cyc();
  endtask

  logic [15:0] sx [8];
  logic [15:0] se [8];
  logic        sm [8];
  int          ni, no;
  logic        pv, pr, acc, xfer;
  logic [15:0] pd;
  logic [3:0]  pt;

  initial begin
    repeat (3) @(negedge clk);
    #1 chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_odata", 32'(out_data), 0);
    chk("rst_otag", 32'(out_tag), 0);
    chk("rst_irdy", 32'(in_ready), 0);
    rst = 1'b1;
    #1 chk("rel_irdy", 32'(in_ready), 1);
    cyc();

    lat("sig_0", 16'h0000, 1'b0, 4'h1, 16'h0800);
    lat("sig_1", 16'h1000, 1'b0, 4'h2, 16'h0C00);
    lat("sig_m1", 16'hF000, 1'b0, 4'h3, 16'h0400);
    lat("sig_6", 16'h6000, 1'b0, 4'h4, 16'h1000);
    lat("sig_min", 16'h8000, 1'b0, 4'h5, 16'h0000);
    lat("sig_2p375", 16'h2600, 1'b0, 4'h6, 16'h0EB0);
`ifdef PWL_ACT_TANH_EN
    lat("tanh_0p5", 16'h0800, 1'b1, 4'h7, 16'h0800);
    lat("tanh_2", 16'h2000, 1'b1, 4'h8, 16'h0F00);
    lat("tanh_m2", 16'hE000, 1'b1, 4'h9, 16'hF100);
`else
    lat("nomacro_mode1", 16'h1000, 1'b1, 4'h7, 16'h0C00);
`endif

    sx[0] = 16'h0000; sm[0] = 1'b0; se[0] = 16'h0800;
    sx[1] = 16'h0800; sm[1] = 1'b1;
    sx[2] = 16'h1000; sm[2] = 1'b0; se[2] = 16'h0C00;
    sx[3] = 16'h2000; sm[3] = 1'b1;
    sx[4] = 16'hF000; sm[4] = 1'b0; se[4] = 16'h0400;
    sx[5] = 16'hE000; sm[5] = 1'b1;
    sx[6] = 16'h6000; sm[6] = 1'b0; se[6] = 16'h1000;
    sx[7] = 16'h0000; sm[7] = 1'b1;
`ifdef PWL_ACT_TANH_EN
    se[1] = 16'h0800; se[3] = 16'h0F00;
    se[5] = 16'hF100; se[7] = 16'h0000;
`else
    se[1] = 16'h0A00; se[3] = 16'h0E00;
    se[5] = 16'h0200; se[7] = 16'h0800;
`endif

    ni = 0; no = 0; pv = 1'b0; pr = 1'b1; pd = '0; pt = '0;
    for (int c = 0; c < 80 && no < 8; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      if (ni < 8) begin
        in_valid = 1'b1;
        in_data  = sx[ni];
        in_mode  = sm[ni];
        in_tag   = 4'(ni + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (pv && !pr) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(pd));
        chk("stall_tag", 32'(out_tag), 32'(pt));
      end
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        chk("strm_data", 32'(out_data), 32'(se[no]));
        chk("strm_tag", 32'(out_tag), no + 1);
        no++;
      end
      pv = out_valid; pr = out_ready;
      pd = out_data;  pt = out_tag;
      cyc();
      if (acc) ni++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("strm_count", no, 8);
    #1 chk("strm_nodup", 32'(out_valid), 0);
    cyc();

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h1000;
      in_mode  = 1'b0;
      in_tag   = 4'(10 + i);
      cyc();
    end
    in_valid = 1'b0;
    #1 chk("full_irdy", 32'(in_ready), 0);
    chk("full_ovalid", 32'(out_valid), 1);
    cyc();
    rst = 1'b0;
    cyc();
    #1 chk("mid_rst_ovalid", 32'(out_valid), 0);
    chk("mid_rst_odata", 32'(out_data), 0);
    chk("mid_rst_irdy", 32'(in_ready), 0);
    rst = 1'b1;
    out_ready = 1'b1;
    #1 chk("mid_rel_irdy", 32'(in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1 chk("flush_ovalid", 32'(out_valid), 0);
    end
    cyc();
    lat("post_rst", 16'h0000, 1'b0, 4'h5, 16'h0800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
